pipe_ctrl: RTL and testbench

//  Pipeline stall/flush controller. It produces the stall[5:0] vector that the

---
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: arbitrates the shared SRAM bus between fetch
// and MEM-stage accesses, builds the per-stage stall vector and defers flushes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | bus free; arbitrate mem_req over if_req
// MEM_BUSY | bus owned by MEM stage; wait_cnt counts down to done
// IF_BUSY  | bus owned by fetch; wait_cnt counts down to done
module pipe_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic             mem_req,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             flush_req,
   output logic             if_grant,
   output logic             mem_grant,
   output logic             if_done,
   output logic             mem_done,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_BUSY = 2'd1,
      IF_BUSY  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              flush_pend, flush_pend_nxt;
   logic              mem_pend, if_pend;
   logic              term_cnt;

   assign term_cnt = (wait_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         flush_pend <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         flush_pend <= flush_pend_nxt;
         if ((stall != 6'b000000) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      flush_pend_nxt = flush_pend;
      if_grant       = 1'b0;
      mem_grant      = 1'b0;
      if_done        = 1'b0;
      mem_done       = 1'b0;
      mem_pend       = 1'b0;
      if_pend        = 1'b0;
      flush          = 1'b0;
      stall          = 6'b000000;

      case (state)
         IDLE: begin
            if (mem_req) begin
               mem_pend     = 1'b1;
               state_nxt    = MEM_BUSY;
               wait_cnt_nxt = WAIT_LOAD;
            end else if (if_req) begin
               if_pend      = 1'b1;
               state_nxt    = IF_BUSY;
               wait_cnt_nxt = WAIT_LOAD;
            end
         end
         MEM_BUSY: begin
            mem_grant = 1'b1;
            if (term_cnt) begin
               mem_done  = 1'b1;
               state_nxt = IDLE;
            end else begin
               mem_pend     = 1'b1;
               wait_cnt_nxt = wait_cnt - 1'b1;
            end
         end
         IF_BUSY: begin
            if_grant = 1'b1;
            if (term_cnt) begin
               if_done   = 1'b1;
               state_nxt = IDLE;
            end else begin
               if_pend      = 1'b1;
               wait_cnt_nxt = wait_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase

      // A deferred flush waits out the done cycle so the load/store retires first.
      if (!mem_pend) begin
         flush = flush_req || (flush_pend && !mem_done);
      end

      if (flush) begin
         flush_pend_nxt = 1'b0;
      end else if (flush_req && mem_pend) begin
         flush_pend_nxt = 1'b1;
      end

      if (mem_pend) begin
         stall = 6'b011111;
      end else if (stallreq_ex) begin
         stall = 6'b001111;
      end else if (stallreq_id && !flush) begin
         stall = 6'b000111;
      end else if (if_pend && !flush) begin
         stall = 6'b000011;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle stimulus tables push expected
// outputs into a scoreboard queue that is popped and compared at the negedge.
module tb_pipe_ctrl;

   localparam int WAIT_CYCLES = 2;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             if_req = 1'b0;
   logic             mem_req = 1'b0;
   logic             stallreq_id = 1'b0;
   logic             stallreq_ex = 1'b0;
   logic             flush_req = 1'b0;
   logic             if_grant;
   logic             mem_grant;
   logic             if_done;
   logic             mem_done;
   logic [5:0]       stall;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;

   pipe_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .mem_req     (mem_req),
      .stallreq_id (stallreq_id),
      .stallreq_ex (stallreq_ex),
      .flush_req   (flush_req),
      .if_grant    (if_grant),
      .mem_grant   (mem_grant),
      .if_done     (if_done),
      .mem_done    (mem_done),
      .stall       (stall),
      .flush       (flush),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // outputs packed as {if_grant, mem_grant, if_done, mem_done, stall[5:0], flush}
   logic [10:0] obs;
   assign obs = {if_grant, mem_grant, if_done, mem_done, stall, flush};

   int          checks = 0;
   int          errors = 0;
   int          exp_cnt = 0;
   logic        prev_rst = 1'b1;
   logic [5:0]  prev_st = 6'b000000;
   logic [10:0] sb[$];

   // inputs packed as {rst, if_req, mem_req, stallreq_id, stallreq_ex, flush_req}
   function automatic logic [16:0] vec(input logic [5:0] i, input logic [10:0] o);
      return {i, o};
   endfunction

   // Advance one cycle: account the previous cycle in the counter model, then
   // apply this cycle's inputs and queue its expected outputs.
   task automatic drive(input logic [16:0] v);
      @(posedge clk);
      if (prev_rst) exp_cnt = 0;
      else if ((prev_st != 6'b000000) && (exp_cnt < CNT_MAX)) exp_cnt++;
      #1;
      {rst, if_req, mem_req, stallreq_id, stallreq_ex, flush_req} = v[16:11];
      prev_rst = v[16];
      prev_st  = v[6:1];
      sb.push_back(v[10:0]);
   endtask

   task automatic test_reset();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b1_0_0_0_0_0, 11'b0), vec(6'b1_0_0_0_0_0, 11'b0), vec(6'b0, 11'b0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL reset cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_idle();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      repeat (10) tbl.push_back(vec(6'b0, 11'b0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL idle cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL idle cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_fetch();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_1_0_0_0_0, 11'b0_0_0_0_000011_0),
             vec(6'b0,           11'b1_0_0_0_000011_0),
             vec(6'b0,           11'b1_0_1_0_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL fetch cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL fetch cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_mem_priority();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_1_1_0_0_0, 11'b0_0_0_0_011111_0),
             vec(6'b0_1_0_0_0_0, 11'b0_1_0_0_011111_0),
             vec(6'b0_1_0_0_0_0, 11'b0_1_0_1_000000_0),
             vec(6'b0_1_0_0_0_0, 11'b0_0_0_0_000011_0),
             vec(6'b0,           11'b1_0_0_0_000011_0),
             vec(6'b0,           11'b1_0_1_0_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL mem_priority cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL mem_priority cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_stallreq();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      repeat (3) tbl.push_back(vec(6'b0_0_0_1_1_0, 11'b0_0_0_0_001111_0));
      tbl.push_back(vec(6'b0_0_0_1_0_0, 11'b0_0_0_0_000111_0));
      tbl.push_back(vec(6'b0_0_0_0_1_0, 11'b0_0_0_0_001111_0));
      tbl.push_back(vec(6'b0,           11'b0_0_0_0_000000_0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL stallreq cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL stallreq cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_flush_deferred();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_0_1_0_0_0, 11'b0_0_0_0_011111_0),
             vec(6'b0_0_0_0_0_1, 11'b0_1_0_0_011111_0),
             vec(6'b0,           11'b0_1_0_1_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_1),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL flush_deferred cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_deferred cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_flush_direct();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_1_0_1_0_1, 11'b0_0_0_0_000000_1),
             vec(6'b0,           11'b1_0_0_0_000011_0),
             vec(6'b0_0_0_0_0_1, 11'b1_0_1_0_000000_1),
             vec(6'b0_0_0_0_1_1, 11'b0_0_0_0_001111_1),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL flush_direct cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_direct cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_0_1_0_0_0, 11'b0_0_0_0_011111_0),
             vec(6'b0_0_1_0_0_1, 11'b0_1_0_0_011111_0),
             vec(6'b0_0_1_0_0_0, 11'b0_1_0_1_000000_0),
             vec(6'b0_0_1_0_0_0, 11'b0_0_0_0_011111_0),
             vec(6'b0,           11'b0_1_0_0_011111_0),
             vec(6'b0,           11'b0_1_0_1_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_1),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL back_to_back cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      tbl = {vec(6'b0_0_1_0_0_0, 11'b0_0_0_0_011111_0),
             vec(6'b1_0_0_0_0_0, 11'b0_1_0_0_011111_0),
             vec(6'b0,           11'b0_0_0_0_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_0),
             vec(6'b0,           11'b0_0_0_0_000000_0)};
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_access cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL reset_mid_access cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_saturate();
      logic [16:0] tbl[$];
      logic [10:0] exp;
      repeat (CNT_MAX + 20) tbl.push_back(vec(6'b0_0_0_0_1_0, 11'b0_0_0_0_001111_0));
      tbl.push_back(vec(6'b0, 11'b0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL saturate cyc %0d outputs got %b want %b", i, obs, exp);
         end
         checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL saturate cyc %0d stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
      checks++;
      if (stall_cnt !== CNT_W'(CNT_MAX)) begin
         errors++;
         $display("FAIL saturate final stall_cnt got %0d want %0d", stall_cnt, CNT_MAX);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_fetch();
      test_mem_priority();
      test_stallreq();
      test_flush_deferred();
      test_flush_direct();
      test_back_to_back();
      test_reset_mid_access();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
